mem_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one single-port Memory instance between NREQ requesters.
//  - Each requester posts one read or write command.
//  - The arbiter picks one winner, latches its command and drives the Memory wr_en/rd_en/addr/datain for one cycle.
//  - It captures read data from Memory dataout and signals completion to the winner.
//  - Sits between client blocks (CPU port, DMA, test loader) and Memory; it is the only driver of Memory's access inputs.

---
 rtl/mem_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port Memory among NREQ requesters.
// Latency: req seen in IDLE at edge E -> gnt_o in cycle E+1 -> done_o in cycle E+2.
// Backpressure: requesters hold req_i until their done_o; losers simply wait, nothing is dropped.
package definitions;
    localparam int ADDRWIDTH = 8;
    localparam int DATAWIDTH = 32;
endpackage

module mem_rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDRWIDTH = definitions::ADDRWIDTH,
    parameter int DATAWIDTH = definitions::DATAWIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ-1:0]           we_i,
    input  logic [NREQ*ADDRWIDTH-1:0] addr_i,
    input  logic [NREQ*DATAWIDTH-1:0] wdata_i,
    output logic [NREQ-1:0]           gnt_o,
    output logic [NREQ-1:0]           done_o,
    output logic [DATAWIDTH-1:0]      rdata_o,
    output logic                      busy_o,
    output logic                      mem_wr_en,
    output logic                      mem_rd_en,
    output logic [ADDRWIDTH-1:0]      mem_addr,
    output logic [DATAWIDTH-1:0]      mem_datain,
    input  logic [DATAWIDTH-1:0]      mem_dataout,
    input  logic                      mem_datavalid
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          win_q;
    logic                   we_q;
    logic [ADDRWIDTH-1:0]   addr_q;
    logic [DATAWIDTH-1:0]   wdata_q;
    logic [DATAWIDTH-1:0]   rdata_q;

    logic [NREQ-1:0]        cand;
    logic                   pick_vld;
    logic [IW-1:0]          pick_idx;
    logic                   sel_we;
    logic [ADDRWIDTH-1:0]   sel_addr;
    logic [DATAWIDTH-1:0]   sel_wdata;
    logic                   load;

    // In DONE the finishing requester is masked: its req is still high this cycle.
    always_comb begin
        int k;
        k        = 0;
        cand     = req_i;
        pick_vld = 1'b0;
        pick_idx = '0;
        if (state == DONE) cand[win_q] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!pick_vld && cand[IW'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(k);
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_we    = we_i[i];
                sel_addr  = addr_i[i*ADDRWIDTH +: ADDRWIDTH];
                sel_wdata = wdata_i[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = DONE;
            DONE: begin
                if (pick_vld) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            win_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                win_q   <= pick_idx;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state == DONE)
                rr_ptr <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            if (state == ACCESS && !we_q && mem_datavalid)
                rdata_q <= mem_dataout;
        end
    end

    // Memory strobes decode straight from state so an async reset kills an in-flight write.
    always_comb begin
        gnt_o      = '0;
        done_o     = '0;
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        mem_datain = '0;
        if (state == ACCESS) begin
            gnt_o[win_q] = 1'b1;
            mem_wr_en    = we_q;
            mem_rd_en    = ~we_q;
            mem_addr     = addr_q;
            mem_datain   = we_q ? wdata_q : '0;
        end
        if (state == DONE) done_o[win_q] = 1'b1;
    end

    assign busy_o  = (state != IDLE);
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural single-port memory attached.
module tb_mem_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_i, we_i;
    logic [31:0] addr_i;
    logic [127:0] wdata_i;
    logic [3:0]  gnt_o, done_o;
    logic [31:0] rdata_o;
    logic        busy_o, mem_wr_en, mem_rd_en, mem_datavalid;
    logic [7:0]  mem_addr;
    logic [31:0] mem_datain, mem_dataout;

    logic [31:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_rr_arbiter #(.NREQ(4), .ADDRWIDTH(8), .DATAWIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o),
        .busy_o(busy_o), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_dataout(mem_dataout),
        .mem_datavalid(mem_datavalid)
    );

    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_datain;
    assign mem_dataout   = mem[mem_addr];
    assign mem_datavalid = mem_rd_en;

    typedef struct {
        logic        rst;
        logic [3:0]  req, we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  gnt, done;
        logic        busy, wr, rd;
        logic [7:0]  maddr;
        logic [31:0] mdin, rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [3:0] w,
                                input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] g, input logic [3:0] dn,
                                input logic b, input logic wr, input logic rd,
                                input logic [7:0] ma, input logic [31:0] md,
                                input logic [31:0] rdat);
        vec_t v;
        v.rst = rst; v.req = rq; v.we = w; v.addr = a; v.wdata = d;
        v.gnt = g; v.done = dn; v.busy = b; v.wr = wr; v.rd = rd;
        v.maddr = ma; v.mdin = md; v.rdata = rdat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rq, input logic [3:0] w, input logic [7:0] a,
                         input logic [31:0] d);
        req_i   = rq;
        we_i    = w;
        addr_i  = {4{a}};
        wdata_i = {4{d}};
    endtask

    // One complete access by requester k; returns rdata_o seen in its done cycle.
    task automatic do_access(input int k, input logic w, input logic [7:0] a,
                             input logic [31:0] d, output logic [31:0] rd);
        logic [3:0] m;
        bit seen;
        m = 4'b0001 << k;
        seen = 0;
        rd = '0;
        @(negedge clk);
        drive(m, w ? m : 4'b0000, a, d);
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            if (done_o != 4'b0000) begin
                seen = 1;
                chk($sformatf("access%0d done", k), {28'd0, done_o}, {28'd0, m});
                rd = rdata_o;
            end
        end
        if (!seen) begin
            n_err++;
            $display("FAIL access%0d timeout: got no done_o, want done_o=%b", k, m);
        end
        drive(4'b0000, 4'b0000, 8'h00, 32'h0);
    endtask

    localparam logic [31:0] D1 = 32'hA5A5_0001;
    localparam logic [31:0] D2 = 32'h0000_1234;

    initial begin
        logic [31:0] tmp;

        // Reset values, with requests present during reset.
        reset = 1'b0;
        drive(4'b1111, 4'b0000, 8'h00, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst gnt",   {28'd0, gnt_o}, 32'd0);
        chk("rst done",  {28'd0, done_o}, 32'd0);
        chk("rst busy",  {31'd0, busy_o}, 32'd0);
        chk("rst wr",    {31'd0, mem_wr_en}, 32'd0);
        chk("rst rd",    {31'd0, mem_rd_en}, 32'd0);
        chk("rst addr",  {24'd0, mem_addr}, 32'd0);
        chk("rst din",   mem_datain, 32'd0);
        chk("rst rdata", rdata_o, 32'd0);
        drive(4'b0000, 4'b0000, 8'h00, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle busy", {31'd0, busy_o}, 32'd0);
        chk("idle gnt",  {28'd0, gnt_o}, 32'd0);

        //              rst req     we      addr   wdata  | gnt     done    b  w  r  maddr  mdin   rdata
        // single write then read by requester 0
        vq.push_back(mk(1, 4'b0001, 4'b0001, 8'h05, D1,    4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  0));
        vq.push_back(mk(1, 4'b0001, 4'b0001, 8'h05, D1,    4'b0001, 4'b0000, 1, 1, 0, 8'h05, D1, 0));
        vq.push_back(mk(1, 4'b0001, 4'b0001, 8'h05, D1,    4'b0000, 4'b0001, 1, 0, 0, 8'h00, 0,  0));
        vq.push_back(mk(1, 4'b0000, 4'b0000, 8'h05, D1,    4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  0));
        vq.push_back(mk(1, 4'b0001, 4'b0000, 8'h05, 0,     4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  0));
        vq.push_back(mk(1, 4'b0001, 4'b0000, 8'h05, 0,     4'b0001, 4'b0000, 1, 0, 1, 8'h05, 0,  0));
        vq.push_back(mk(1, 4'b0001, 4'b0000, 8'h05, 0,     4'b0000, 4'b0001, 1, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b0000, 4'b0000, 8'h05, 0,     4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  D1));
        // reset to rr_ptr=0, then all four contend: order 0,1,2,3,0
        vq.push_back(mk(0, 4'b0000, 4'b0000, 8'h05, 0,     4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  0));
        vq.push_back(mk(1, 4'b1111, 4'b0000, 8'h05, 0,     4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  0));
        vq.push_back(mk(1, 4'b1111, 4'b0000, 8'h05, 0,     4'b0001, 4'b0000, 1, 0, 1, 8'h05, 0,  0));
        vq.push_back(mk(1, 4'b1111, 4'b0000, 8'h05, 0,     4'b0000, 4'b0001, 1, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b1111, 4'b0000, 8'h05, 0,     4'b0010, 4'b0000, 1, 0, 1, 8'h05, 0,  D1));
        vq.push_back(mk(1, 4'b1111, 4'b0000, 8'h05, 0,     4'b0000, 4'b0010, 1, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b1111, 4'b0000, 8'h05, 0,     4'b0100, 4'b0000, 1, 0, 1, 8'h05, 0,  D1));
        vq.push_back(mk(1, 4'b1111, 4'b0000, 8'h05, 0,     4'b0000, 4'b0100, 1, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b1111, 4'b0000, 8'h05, 0,     4'b1000, 4'b0000, 1, 0, 1, 8'h05, 0,  D1));
        vq.push_back(mk(1, 4'b1111, 4'b0000, 8'h05, 0,     4'b0000, 4'b1000, 1, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b1111, 4'b0000, 8'h05, 0,     4'b0001, 4'b0000, 1, 0, 1, 8'h05, 0,  D1));
        vq.push_back(mk(1, 4'b0000, 4'b0000, 8'h05, 0,     4'b0000, 4'b0001, 1, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b0000, 4'b0000, 8'h05, 0,     4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  D1));
        // serve requester 2 alone to leave rr_ptr=3, then 4'b1001 -> grant 3 then 0
        vq.push_back(mk(1, 4'b0100, 4'b0000, 8'h05, 0,     4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b0100, 4'b0000, 8'h05, 0,     4'b0100, 4'b0000, 1, 0, 1, 8'h05, 0,  D1));
        vq.push_back(mk(1, 4'b0100, 4'b0000, 8'h05, 0,     4'b0000, 4'b0100, 1, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b1001, 4'b0000, 8'h05, 0,     4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b1001, 4'b0000, 8'h05, 0,     4'b1000, 4'b0000, 1, 0, 1, 8'h05, 0,  D1));
        vq.push_back(mk(1, 4'b1001, 4'b0000, 8'h05, 0,     4'b0000, 4'b1000, 1, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b1001, 4'b0000, 8'h05, 0,     4'b0001, 4'b0000, 1, 0, 1, 8'h05, 0,  D1));
        vq.push_back(mk(1, 4'b0000, 4'b0000, 8'h05, 0,     4'b0000, 4'b0001, 1, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b0000, 4'b0000, 8'h05, 0,     4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  D1));
        // requester 1 writes 0x20, requester 2 reads it back-to-back
        vq.push_back(mk(1, 4'b0110, 4'b0010, 8'h20, D2,    4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b0110, 4'b0010, 8'h20, D2,    4'b0010, 4'b0000, 1, 1, 0, 8'h20, D2, D1));
        vq.push_back(mk(1, 4'b0110, 4'b0010, 8'h20, D2,    4'b0000, 4'b0010, 1, 0, 0, 8'h00, 0,  D1));
        vq.push_back(mk(1, 4'b0100, 4'b0010, 8'h20, D2,    4'b0100, 4'b0000, 1, 0, 1, 8'h20, 0,  D1));
        vq.push_back(mk(1, 4'b0100, 4'b0000, 8'h20, D2,    4'b0000, 4'b0100, 1, 0, 0, 8'h00, 0,  D2));
        vq.push_back(mk(1, 4'b0000, 4'b0000, 8'h20, D2,    4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0,  D2));

        foreach (vq[i]) begin
            @(negedge clk);
            reset = vq[i].rst;
            drive(vq[i].req, vq[i].we, vq[i].addr, vq[i].wdata);
            #1;
            chk($sformatf("v%0d gnt", i),   {28'd0, gnt_o},     {28'd0, vq[i].gnt});
            chk($sformatf("v%0d done", i),  {28'd0, done_o},    {28'd0, vq[i].done});
            chk($sformatf("v%0d busy", i),  {31'd0, busy_o},    {31'd0, vq[i].busy});
            chk($sformatf("v%0d wr", i),    {31'd0, mem_wr_en}, {31'd0, vq[i].wr});
            chk($sformatf("v%0d rd", i),    {31'd0, mem_rd_en}, {31'd0, vq[i].rd});
            chk($sformatf("v%0d maddr", i), {24'd0, mem_addr},  {24'd0, vq[i].maddr});
            chk($sformatf("v%0d mdin", i),  mem_datain,         vq[i].mdin);
            chk($sformatf("v%0d rdata", i), rdata_o,            vq[i].rdata);
        end
        reset = 1'b1;

        // Reset during the ACCESS cycle of a write must not commit it.
        do_access(0, 1'b1, 8'h10, 32'h0000_BEEF, tmp);
        @(negedge clk);
        drive(4'b0001, 4'b0001, 8'h10, 32'h0000_DEAD);
        @(posedge clk);
        #2;
        chk("abort pre gnt", {28'd0, gnt_o}, 32'd1);
        chk("abort pre wr",  {31'd0, mem_wr_en}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort wr",   {31'd0, mem_wr_en}, 32'd0);
        chk("abort addr", {24'd0, mem_addr}, 32'd0);
        chk("abort din",  mem_datain, 32'd0);
        chk("abort gnt",  {28'd0, gnt_o}, 32'd0);
        chk("abort busy", {31'd0, busy_o}, 32'd0);
        drive(4'b0000, 4'b0000, 8'h00, 32'h0);
        @(negedge clk);
        chk("abort done", {28'd0, done_o}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort idle done", {28'd0, done_o}, 32'd0);
        do_access(0, 1'b0, 8'h10, 32'h0, tmp);
        chk("abort readback", tmp, 32'h0000_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
